// File: rtl/serial_deserializer_if.sv
// Bundles the frame-input, consumer handshake and status signals of
// serial_deserializer. The master drives the serial side and consumer
// controls. The slave is the deserializer itself.
interface serial_deserializer_if #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) ();
   logic             start;
   logic             bit_in;
   logic             bit_valid;
   logic             word_ready;
   logic             clr_ovr;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             busy;
   logic [CW-1:0]    bit_count;
   logic             overrun;

   modport master (
      output start, bit_in, bit_valid, word_ready, clr_ovr,
      input  word, word_valid, busy, bit_count, overrun
   );

   modport slave (
      input  start, bit_in, bit_valid, word_ready, clr_ovr,
      output word, word_valid, busy, bit_count, overrun
   );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter for the single-bit stream leaving the
// d_flip_flop stage. Frames open with a start strobe. Bits qualified by
// bit_valid are shifted in MSB-first. Each completed word is offered to a
// one-deep output register with a valid/ready handshake. A completed word is
// dropped if it arrives while an unconsumed word is still held, and the drop
// is recorded in a sticky overrun flag.
module serial_deserializer #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   serial_deserializer_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state_q, state_d;
   // Only WIDTH-1 bits are kept. The final bit joins them directly on completion.
   logic [WIDTH-2:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] full_word;
   logic             done;
   logic             load;
   logic             drop;

   logic [WIDTH-1:0] word_q;
   logic             word_valid_q;
   logic             overrun_q;

   // State, shift register and bit counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. Start outranks both shifting and completion.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      done      = 1'b0;
      full_word = {sreg_q, bus.bit_in};
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SHIFT;
               sreg_d  = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (bus.start) begin
               sreg_d = '0;
               cnt_d  = '0;
            end else if (bus.bit_valid) begin
               sreg_d = full_word[WIDTH-2:0];
               if (cnt_q == CW'(WIDTH - 1)) begin
                  done    = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A completed word loads when the holding register is empty or is being
   // drained on the same edge. Otherwise the word is lost.
   assign load = done && (!word_valid_q || bus.word_ready);
   assign drop = done && word_valid_q && !bus.word_ready;

   // One-deep output register with a sticky overrun flag. A drop outranks clr_ovr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_q       <= '0;
         word_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         if (load) begin
            word_q       <= full_word;
            word_valid_q <= 1'b1;
         end else if (bus.word_ready) begin
            word_valid_q <= 1'b0;
         end
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (bus.clr_ovr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign bus.word       = word_q;
   assign bus.word_valid = word_valid_q;
   assign bus.busy       = (state_q == SHIFT);
   assign bus.bit_count  = cnt_q;
   assign bus.overrun    = overrun_q;

endmodule
